// File: rtl/bytecode_fetch.sv
// Fetches one JVM instruction byte-by-byte, packs opcode+operands, hands it to the decoder, advances PC.
// Latency: 1-byte instruction with zero-wait memory -> mem_ack in fetch cycle, dec_start the next cycle.
// Backpressure: memory stalls hold mem_req/mem_addr; decoder busy (dec_ready low) stalls all fetching.
// Optional illegal-opcode trap enabled by defining BYTECODE_FETCH_ILLEGAL_TRAP_EN.
module bytecode_fetch #(
    parameter int                 ADDR_W   = 16,
    parameter int                 WORD_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_data,
    output logic              dec_start,
    input  logic              dec_ready,
    output logic [WORD_W-1:0] dec_instr,
    output logic [ADDR_W-1:0] pc,
`ifdef BYTECODE_FETCH_ILLEGAL_TRAP_EN
    output logic              illegal,
`endif
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_OP,
        S_FETCH_OPND,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE
`ifdef BYTECODE_FETCH_ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q;
    logic [WORD_W-1:0]   instr_q;
    logic [1:0]          opnd_cnt_q;
    logic [1:0]          remain_q;
    logic [1:0]          idx_q;
    logic                pend_vld_q;
    logic [ADDR_W-1:0]   pend_addr_q;
    logic                capture_load;

    // Number of operand bytes following each opcode.
    function automatic logic [1:0] opnd_count(input logic [7:0] op);
        logic [1:0] n;
        case (op) inside
            8'h10, 8'h12, 8'h15, 8'h16, 8'h18: n = 2'd1;
            8'h11, 8'h84, [8'h99:8'hA7]:       n = 2'd2;
            default:                           n = 2'd0;
        endcase
        return n;
    endfunction

`ifdef BYTECODE_FETCH_ILLEGAL_TRAP_EN
    // Opcodes reserved or undefined for this core.
    function automatic logic is_trap_op(input logic [7:0] op);
        return (op == 8'hBA) || ((op >= 8'hCB) && (op <= 8'hFD)) || (op == 8'hFF);
    endfunction

    assign illegal = (state_q == S_TRAP);
`endif

    assign busy      = (state_q != S_IDLE);
    assign pc        = pc_q;
    assign dec_instr = instr_q;

    // Next-state and handshake outputs; memory signals derive from state so mem_req drops right after ack.
    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_addr     = '0;
        dec_start    = 1'b0;
        capture_load = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH_OP;
            end
            S_FETCH_OP: begin
                mem_req      = 1'b1;
                mem_addr     = pc_q;
                capture_load = pc_load;
                if (mem_ack) begin
`ifdef BYTECODE_FETCH_ILLEGAL_TRAP_EN
                    if (is_trap_op(mem_data))
                        state_d = S_TRAP;
                    else
`endif
                    if (opnd_count(mem_data) != 2'd0)
                        state_d = S_FETCH_OPND;
                    else
                        state_d = S_ISSUE;
                end
            end
            S_FETCH_OPND: begin
                mem_req      = 1'b1;
                mem_addr     = pc_q + ADDR_W'(idx_q);
                capture_load = pc_load;
                if (mem_ack && (remain_q == 2'd1)) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                capture_load = pc_load;
                if (dec_ready) begin
                    dec_start = 1'b1;
                    state_d   = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                capture_load = pc_load;
                if (!dec_ready) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // a load coinciding with completion is applied directly instead of being parked
                capture_load = pc_load && !dec_ready;
                if (dec_ready) state_d = run ? S_FETCH_OP : S_IDLE;
            end
`ifdef BYTECODE_FETCH_ILLEGAL_TRAP_EN
            S_TRAP: begin
                if (pc_load) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State, PC, instruction assembly and pending-redirect bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            instr_q     <= '0;
            opnd_cnt_q  <= 2'd0;
            remain_q    <= 2'd0;
            idx_q       <= 2'd0;
            pend_vld_q  <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture_load) begin
                pend_vld_q  <= 1'b1;
                pend_addr_q <= pc_load_addr;
            end
            case (state_q)
                S_IDLE: begin
                    if (pc_load) pc_q <= pc_load_addr;
                end
                S_FETCH_OP: begin
                    if (mem_ack) begin
                        instr_q                  <= '0;
                        instr_q[WORD_W-1 -: 8]   <= mem_data;
                        opnd_cnt_q               <= opnd_count(mem_data);
                        remain_q                 <= opnd_count(mem_data);
                        idx_q                    <= 2'd1;
                    end
                end
                S_FETCH_OPND: begin
                    if (mem_ack) begin
                        if (idx_q == 2'd1)
                            instr_q[WORD_W-9 -: 8]  <= mem_data;
                        else
                            instr_q[WORD_W-17 -: 8] <= mem_data;
                        idx_q    <= idx_q + 2'd1;
                        remain_q <= remain_q - 2'd1;
                    end
                end
                S_WAIT_DONE: begin
                    if (dec_ready) begin
                        if (pc_load)
                            pc_q <= pc_load_addr;
                        else if (pend_vld_q)
                            pc_q <= pend_addr_q;
                        else
                            pc_q <= pc_q + ADDR_W'(opnd_cnt_q) + ADDR_W'(1);
                        pend_vld_q <= 1'b0;
                    end
                end
`ifdef BYTECODE_FETCH_ILLEGAL_TRAP_EN
                S_TRAP: begin
                    if (pc_load) begin
                        pc_q       <= pc_load_addr;
                        pend_vld_q <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bytecode_fetch.sv
// Randomized bench for bytecode_fetch: random memory latency, decoder busy time and PC redirects.
// Expected words and PC sequence come from a byte-array program memory and the operand-length table.
// Runs the default build (illegal-opcode trap disabled).
module tb_bytecode_fetch;

    logic        clk = 1'b0;
    logic        reset, run, pc_load;
    logic [15:0] pc_load_addr;
    logic        mem_req, mem_ack;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        dec_start, dec_ready;
    logic [31:0] dec_instr;
    logic [15:0] pc;
    logic        busy;

    always #5 clk = ~clk;

    bytecode_fetch #(.ADDR_W(16), .WORD_W(32), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .run(run),
        .pc_load(pc_load), .pc_load_addr(pc_load_addr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .dec_start(dec_start), .dec_ready(dec_ready), .dec_instr(dec_instr),
        .pc(pc), .busy(busy)
    );

    logic [7:0] mem [0:65535];
    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Operand bytes per opcode, straight from the opcode table.
    function automatic int n_opnd(input logic [7:0] op);
        if (op == 8'h11 || op == 8'h84 || (op >= 8'h99 && op <= 8'hA7)) return 2;
        if (op == 8'h10 || op == 8'h12 || op == 8'h15 || op == 8'h16 || op == 8'h18) return 1;
        return 0;
    endfunction

    // Packed word the decoder should see for the instruction at address a.
    function automatic logic [31:0] word_at(input logic [15:0] a);
        int          n;
        logic [15:0] a1, a2;
        n  = n_opnd(mem[a]);
        a1 = a + 16'd1;
        a2 = a + 16'd2;
        return {mem[a], (n >= 1) ? mem[a1] : 8'h00, (n >= 2) ? mem[a2] : 8'h00, 8'h00};
    endfunction

    function automatic logic [15:0] pick_target();
        case ($urandom_range(0, 3))
            0:       return 16'hFFFF;
            1:       return 16'hFFFE;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic [7:0]  hot [10];
        logic [15:0] exp_pc, ea, pend_tgt;
        logic [31:0] exp_word;
        int          k, n_cur, phase, hold, wait_cnt, instr_cnt, stall;
        logic        pend_vld;

        hot = '{8'h10, 8'h11, 8'h12, 8'h15, 8'h16, 8'h18, 8'h84, 8'h99, 8'hA0, 8'hA7};
        for (int i = 0; i < 65536; i++)
            mem[i] = ($urandom_range(0, 2) == 0) ? hot[$urandom_range(0, 9)] : 8'($urandom);
        mem[0] = 8'h60; mem[1] = 8'h11; mem[2] = 8'h12; mem[3] = 8'h34;
        mem[16'hFFFF] = 8'h10;

        reset = 1'b0; run = 1'b0; pc_load = 1'b0; pc_load_addr = '0;
        mem_ack = 1'b0; mem_data = '0; dec_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_pc", pc, 16'h0000);
        check_eq("rst_mem_req", mem_req, 1'b0);
        check_eq("rst_mem_addr", mem_addr, 16'h0000);
        check_eq("rst_dec_start", dec_start, 1'b0);
        check_eq("rst_dec_instr", dec_instr, 32'h0);
        check_eq("rst_busy", busy, 1'b0);

        // start a fetch, then reset while it is outstanding and ack it late
        reset = 1'b1; run = 1'b1;
        for (int i = 0; i < 5 && !mem_req; i++) @(negedge clk);
        check_eq("req_before_reset", mem_req, 1'b1);
        reset = 1'b0; mem_ack = 1'b1; mem_data = 8'h10;
        @(negedge clk);
        reset = 1'b1; run = 1'b0;
        @(negedge clk);
        mem_ack = 1'b0;
        check_eq("late_ack_busy", busy, 1'b0);
        check_eq("late_ack_pc", pc, 16'h0000);
        check_eq("late_ack_instr", dec_instr, 32'h0);
        check_eq("late_ack_req", mem_req, 1'b0);

        run = 1'b1;
        exp_pc = 16'h0000; exp_word = '0; k = 0; n_cur = 0; phase = 0; hold = 0;
        wait_cnt = 0; instr_cnt = 0; stall = 0; pend_vld = 1'b0; pend_tgt = '0;
        for (int cyc = 0; cyc < 20000 && instr_cnt < 400; cyc++) begin
            @(negedge clk);
            pc_load = 1'b0;
            mem_ack = 1'b0;
            stall++;
            if (stall > 200) begin
                check_eq("watchdog_stall", 32'(stall), 32'd0);
                break;
            end
            // redirect while an instruction is in flight: applied when it completes
            if ((phase == 0 || phase == 2) && busy && $urandom_range(0, 15) == 0) begin
                pc_load      = 1'b1;
                pc_load_addr = pick_target();
                pend_vld     = 1'b1;
                pend_tgt     = pc_load_addr;
            end
            case (phase)
                0: begin
                    if (mem_req) begin
                        if (wait_cnt == 0) begin
                            ea = exp_pc + 16'(k);
                            check_eq("mem_addr", mem_addr, ea);
                            mem_ack  = 1'b1;
                            mem_data = mem[mem_addr];
                            k++;
                            wait_cnt = $urandom_range(0, 2);
                            stall    = 0;
                        end else begin
                            wait_cnt--;
                        end
                    end
                    if (dec_start) begin
                        exp_word = word_at(exp_pc);
                        n_cur    = n_opnd(mem[exp_pc]);
                        check_eq("dec_instr", dec_instr, exp_word);
                        check_eq("byte_reads", 32'(k), 32'(n_cur + 1));
                        check_eq("pc_at_issue", pc, exp_pc);
                        phase = 1;
                        stall = 0;
                    end
                end
                1: begin
                    check_eq("start_one_cycle", dec_start, 1'b0);
                    dec_ready = 1'b0;
                    hold  = ($urandom_range(0, 7) == 0) ? 10 : $urandom_range(0, 4);
                    phase = 2;
                end
                2: begin
                    check_eq("instr_hold", dec_instr, exp_word);
                    check_eq("no_req_busy", mem_req, 1'b0);
                    check_eq("busy_high", busy, 1'b1);
                    if (hold == 0) begin
                        dec_ready = 1'b1;
                        if (!pc_load && $urandom_range(0, 7) == 0) begin
                            pc_load      = 1'b1;
                            pc_load_addr = pick_target();
                            pend_vld     = 1'b1;
                            pend_tgt     = pc_load_addr;
                        end
                        exp_pc   = pend_vld ? pend_tgt : exp_pc + 16'(n_cur + 1);
                        pend_vld = 1'b0;
                        k        = 0;
                        instr_cnt++;
                        stall    = 0;
                        if ($urandom_range(0, 7) == 0) begin
                            run   = 1'b0;
                            phase = 3;
                        end else begin
                            phase = 0;
                        end
                    end else begin
                        hold--;
                    end
                end
                3: begin
                    check_eq("idle_busy", busy, 1'b0);
                    check_eq("idle_req", mem_req, 1'b0);
                    check_eq("idle_pc", pc, exp_pc);
                    stall = 0;
                    if ($urandom_range(0, 1) == 0) begin
                        pc_load      = 1'b1;
                        pc_load_addr = pick_target();
                        exp_pc       = pc_load_addr;
                        phase        = 4;
                    end else begin
                        run   = 1'b1;
                        phase = 0;
                    end
                end
                default: begin
                    check_eq("idle_load_pc", pc, exp_pc);
                    run   = 1'b1;
                    phase = 0;
                end
            endcase
        end
        check_eq("instr_count", 32'(instr_cnt), 32'd400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
